// File: rtl/rv_mem_responder_if.sv
// Native picorv32 memory bus between a requesting master and rv_mem_responder.
// The master drives the request fields; the responder returns ready and read data.
interface rv_mem_responder_if;
  logic        i_mem_valid;
  logic        i_mem_instr;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [3:0]  i_mem_wstrb;
  logic        o_mem_ready;
  logic [31:0] o_mem_rdata;

  modport master (
    output i_mem_valid,
    output i_mem_instr,
    output i_mem_addr,
    output i_mem_wdata,
    output i_mem_wstrb,
    input  o_mem_ready,
    input  o_mem_rdata
  );

  modport slave (
    input  i_mem_valid,
    input  i_mem_instr,
    input  i_mem_addr,
    input  i_mem_wdata,
    input  i_mem_wstrb,
    output o_mem_ready,
    output o_mem_rdata
  );
endinterface

// File: rtl/rv_mem_responder.sv
// Word RAM responder for the picorv32 native bus with programmable wait states.
// Optional range checker compiled in with macro RV_MEM_RESP_RANGE_CHECK_EN.
module rv_mem_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] ERR_VALUE = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               reset,
  rv_mem_responder_if.slave  bus,
  output logic               o_busy,
  output logic               o_err,
  output logic [31:0]        o_err_addr
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_C    = 4'(LATENCY);
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_RESP  = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [3:0]    cnt_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [3:0]    wstrb_r;
  logic          in_range_r;
  logic          ready_r;
  logic          busy_r;
  logic [31:0]   rdata_r;
  logic          accept_s;
  logic          enter_resp_s;
  logic [31:0]   req_addr_s;
  logic [3:0]    req_wstrb_s;
  logic          req_in_range_s;
  logic          addr_in_range_s;
  logic [31:0]   offset_s;
  logic [AW-1:0] idx_s;
  logic          unused_s;

  logic [31:0]   mem_r [MEM_WORDS];

`ifdef RV_MEM_RESP_RANGE_CHECK_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  logic          err_r;
  logic [31:0]   err_addr_r;

  assign addr_in_range_s = ({1'b0, bus.i_mem_addr} >= {1'b0, BASE_ADDR}) &&
                           ({1'b0, bus.i_mem_addr} <  END_ADDR);
`else
  assign addr_in_range_s = 1'b1;
`endif

  assign accept_s       = (state_r == ST_IDLE) && bus.i_mem_valid;
  assign enter_resp_s   = (state_nxt_s == ST_RESP);

  // In the acceptance cycle the live request is used, afterwards the latched copy.
  assign req_addr_s     = accept_s ? bus.i_mem_addr  : addr_r;
  assign req_wstrb_s    = accept_s ? bus.i_mem_wstrb : wstrb_r;
  assign req_in_range_s = accept_s ? addr_in_range_s : in_range_r;
  assign offset_s       = req_addr_s - BASE_ADDR;
  assign idx_s          = offset_s[AW+1:2];

  assign unused_s       = ^{bus.i_mem_instr, offset_s};

  // Next-state decode for the IDLE / WAIT / RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_mem_valid) begin
          state_nxt_s = (LAT_C != 4'd0) ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, request latch, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
      in_range_r <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= enter_resp_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (accept_s) begin
        addr_r     <= bus.i_mem_addr;
        wdata_r    <= bus.i_mem_wdata;
        wstrb_r    <= bus.i_mem_wstrb;
        in_range_r <= addr_in_range_s;
        cnt_r      <= LAT_C;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (enter_resp_s && (req_wstrb_s == 4'd0)) begin
        rdata_r <= req_in_range_s ? mem_r[idx_s] : ERR_VALUE;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // RAM write on the edge leaving RESP; reset in RESP discards the write.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_RESP) && in_range_r) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_r[k]) begin
          mem_r[idx_s][8*k +: 8] <= wdata_r[8*k +: 8];
        end
      end
    end
  end

`ifdef RV_MEM_RESP_RANGE_CHECK_EN
  // Sticky record of the first out-of-range access, visible from its RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'd0;
    end else if (enter_resp_s && !req_in_range_s && !err_r) begin
      err_r      <= 1'b1;
      err_addr_r <= req_addr_s;
    end else begin
      err_r      <= err_r;
      err_addr_r <= err_addr_r;
    end
  end

  assign o_err      = err_r;
  assign o_err_addr = err_addr_r;
`else
  assign o_err      = 1'b0;
  assign o_err_addr = 32'd0;
`endif

  assign bus.o_mem_ready = ready_r;
  assign bus.o_mem_rdata = rdata_r;
  assign o_busy          = busy_r;

endmodule
